// File: rtl/wm8978_vol_ctrl.sv
// ---------------------------------------------------------------------------
// wm8978_vol_ctrl
//
// Runtime volume / mute controller and I2C-port arbiter for the WM8978 codec.
// Until init_done is high, the init sequencer's I2C writes are forwarded to
// the I2C master with one cycle of latency. After that, this block owns the
// master. Every accepted key pulse (volume up, volume down, mute) schedules
// a 4-write burst that refreshes R52/R53 (headphone) and R54/R55 (speaker).
//
// Ports:
//   clk            control clock (1 MHz nominal)
//   rst_n          synchronous, active-low reset
//   init_exec      I2C trigger from the init sequencer
//   init_data      {7-bit reg addr, 9-bit data} from the init sequencer
//   init_done      init sequencer finished (level)
//   init_i2c_done  i2c_done forwarded to the init sequencer while in PASS
//   vol_up         1-cycle pulse, raise both volumes by STEP
//   vol_down       1-cycle pulse, lower both volumes by STEP
//   mute           1-cycle pulse, toggle mute
//   i2c_done       one-transfer-complete pulse from the I2C master
//   i2c_exec       1-cycle trigger to the I2C master
//   i2c_data       {addr, data} word to the I2C master
//   phone_vol      current headphone volume
//   spk_vol        current speaker volume
//   muted          current mute state
//   busy           update burst in progress
//   err            sticky I2C timeout flag, cleared only by reset
// ---------------------------------------------------------------------------
module wm8978_vol_ctrl #(
    parameter logic [5:0]  PHONE_INIT = 6'd30,
    parameter logic [5:0]  SPEAK_INIT = 6'd63,
    parameter logic [5:0]  STEP       = 6'd4,
    parameter logic [15:0] TIMEOUT    = 16'd50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_exec,
    input  logic [15:0] init_data,
    input  logic        init_done,
    output logic        init_i2c_done,
    input  logic        vol_up,
    input  logic        vol_down,
    input  logic        mute,
    input  logic        i2c_done,
    output logic        i2c_exec,
    output logic [15:0] i2c_data,
    output logic [5:0]  phone_vol,
    output logic [5:0]  spk_vol,
    output logic        muted,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {
        PASS,
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t      state, state_d;
    logic [5:0]  phone_q, phone_d;
    logic [5:0]  spk_q, spk_d;
    logic        muted_q, muted_d;
    logic        pending_q, pending_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [15:0] data_q, data_d;
    logic        pass_exec_q, pass_exec_d;

    logic        up_ok;
    logic        dn_ok;
    logic        accept;
    logic [6:0]  phone_up, phone_dn;
    logic [6:0]  spk_up, spk_dn;
    logic [5:0]  vol_sel;
    logic [15:0] issue_word;

    // Up and down together cancel each other; mute is independent of both.
    assign up_ok  = vol_up & ~vol_down;
    assign dn_ok  = vol_down & ~vol_up;
    assign accept = up_ok | dn_ok | mute;

    // 7-bit intermediates: bit 6 of the sum flags overflow past 63, bit 6 of
    // the difference flags a borrow below 0.
    assign phone_up = {1'b0, phone_q} + {1'b0, STEP};
    assign phone_dn = {1'b0, phone_q} - {1'b0, STEP};
    assign spk_up   = {1'b0, spk_q} + {1'b0, STEP};
    assign spk_dn   = {1'b0, spk_q} - {1'b0, STEP};

    // idx 0..3 addresses R52..R55. Odd registers carry the update bit in
    // bit 8; bit 7 is always set; the upper pair (idx[1]) holds the speaker.
    assign vol_sel    = idx_q[1] ? spk_q : phone_q;
    assign issue_word = {7'd52 + {5'd0, idx_q}, idx_q[0], 1'b1, muted_q, vol_sel};

    // In ISSUE the word is presented combinationally so it lines up with the
    // exec pulse; data_q then holds it until the next ISSUE.
    assign i2c_exec      = (state == ISSUE) | pass_exec_q;
    assign i2c_data      = (state == ISSUE) ? issue_word : data_q;
    assign init_i2c_done = (state == PASS) & i2c_done;

    assign phone_vol = phone_q;
    assign spk_vol   = spk_q;
    assign muted     = muted_q;
    assign busy      = busy_q;
    assign err       = err_q;

    // Next-state and next-value logic. The FSM part may clear pending when a
    // burst starts; the key part runs afterwards so a key arriving in that
    // same cycle still leaves pending set for a follow-up burst.
    always_comb begin
        state_d     = state;
        phone_d     = phone_q;
        spk_d       = spk_q;
        muted_d     = muted_q;
        pending_d   = pending_q;
        busy_d      = busy_q;
        err_d       = err_q;
        idx_d       = idx_q;
        tcnt_d      = tcnt_q;
        data_d      = data_q;
        pass_exec_d = 1'b0;

        case (state)
            PASS: begin
                pass_exec_d = init_exec;
                data_d      = init_data;
                if (init_done) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (pending_q) begin
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = 2'd0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                data_d  = issue_word;
                tcnt_d  = 16'd0;
                state_d = WAIT;
            end
            WAIT: begin
                tcnt_d = tcnt_q + 16'd1;
                if (i2c_done) begin
                    if (idx_q == 2'd3) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else if (tcnt_q == TIMEOUT - 16'd1) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase

        if (state != PASS) begin
            if (up_ok) begin
                phone_d = (phone_up > 7'd63) ? 6'd63 : phone_up[5:0];
                spk_d   = (spk_up > 7'd63) ? 6'd63 : spk_up[5:0];
            end
            if (dn_ok) begin
                phone_d = phone_dn[6] ? 6'd0 : phone_dn[5:0];
                spk_d   = spk_dn[6] ? 6'd0 : spk_dn[5:0];
            end
            if (mute) begin
                muted_d = ~muted_q;
            end
            if (accept) begin
                pending_d = 1'b1;
            end
        end
    end

    // State and data registers with synchronous active-low reset. Reset
    // drops any burst in flight and returns to pass-through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= PASS;
            phone_q     <= PHONE_INIT;
            spk_q       <= SPEAK_INIT;
            muted_q     <= 1'b0;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= 2'd0;
            tcnt_q      <= 16'd0;
            data_q      <= 16'd0;
            pass_exec_q <= 1'b0;
        end else begin
            state       <= state_d;
            phone_q     <= phone_d;
            spk_q       <= spk_d;
            muted_q     <= muted_d;
            pending_q   <= pending_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            tcnt_q      <= tcnt_d;
            data_q      <= data_d;
            pass_exec_q <= pass_exec_d;
        end
    end

endmodule

// File: tb/tb_wm8978_vol_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wm8978_vol_ctrl
//
// Directed testbench for wm8978_vol_ctrl. A small I2C-master responder
// answers each exec with i2c_done 20 cycles later and records the words
// issued; key pulses are scheduled against the responder's cycle count.
// ---------------------------------------------------------------------------
module tb_wm8978_vol_ctrl;

    localparam logic [15:0] TO = 16'd100;

    logic        clk;
    logic        rst_n;
    logic        init_exec;
    logic [15:0] init_data;
    logic        init_done;
    logic        init_i2c_done;
    logic        vol_up;
    logic        vol_down;
    logic        mute;
    logic        i2c_done;
    logic        i2c_exec;
    logic [15:0] i2c_data;
    logic [5:0]  phone_vol;
    logic [5:0]  spk_vol;
    logic        muted;
    logic        busy;
    logic        err;

    int vectors;
    int miscompares;

    logic [15:0] cap [0:31];
    int          cap_n;
    int          sched_cycle [0:15];
    logic [2:0]  sched_keys [0:15];
    int          sched_n;

    wm8978_vol_ctrl #(
        .PHONE_INIT(6'd30),
        .SPEAK_INIT(6'd63),
        .STEP      (6'd4),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init_exec    (init_exec),
        .init_data    (init_data),
        .init_done    (init_done),
        .init_i2c_done(init_i2c_done),
        .vol_up       (vol_up),
        .vol_down     (vol_down),
        .mute         (mute),
        .i2c_done     (i2c_done),
        .i2c_exec     (i2c_exec),
        .i2c_data     (i2c_data),
        .phone_vol    (phone_vol),
        .spk_vol      (spk_vol),
        .muted        (muted),
        .busy         (busy),
        .err          (err)
    );

    // 10 time-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected control word: {addr, update bit on odd regs, 1, mute, vol}.
    function automatic logic [15:0] vol_word(input logic [6:0] addr,
                                             input logic m,
                                             input logic [5:0] v);
        vol_word = {addr, addr[0], 1'b1, m, v};
    endfunction

    // Synchronous reset pulse, released on a falling edge.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Queue a key pulse {up, down, mute} for cycle c of the next serve call.
    task automatic add_key(input int c, input logic [2:0] keys);
        sched_cycle[sched_n] = c;
        sched_keys[sched_n]  = keys;
        sched_n++;
    endtask

    // Acts as the I2C master for ncycles: records each exec word and answers
    // with a 1-cycle i2c_done 20 cycles later; also drives scheduled keys.
    task automatic serve(input int ncycles);
        int cd;
        cd    = 0;
        cap_n = 0;
        for (int c = 0; c < ncycles; c++) begin
            @(negedge clk);
            i2c_done = 1'b0;
            vol_up   = 1'b0;
            vol_down = 1'b0;
            mute     = 1'b0;
            if (i2c_exec) begin
                if (cap_n < 32) cap[cap_n] = i2c_data;
                cap_n++;
                cd = 20;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) i2c_done = 1'b1;
            end
            for (int s = 0; s < sched_n; s++) begin
                if (sched_cycle[s] == c) {vol_up, vol_down, mute} = sched_keys[s];
            end
        end
        @(negedge clk);
        i2c_done = 1'b0;
        vol_up   = 1'b0;
        vol_down = 1'b0;
        mute     = 1'b0;
        sched_n  = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({i2c_exec, i2c_data, init_i2c_done, muted, busy, err} !== 20'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got exec=%b data=%h idone=%b muted=%b busy=%b err=%b, want all 0",
                     i2c_exec, i2c_data, init_i2c_done, muted, busy, err);
        end
        vectors++;
        if (phone_vol !== 6'd30 || spk_vol !== 6'd63) begin
            miscompares++;
            $display("[TB] FAIL reset_vol: got phone=%0d spk=%0d, want 30/63", phone_vol, spk_vol);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_pass_through();
        @(negedge clk);
        init_exec = 1'b1;
        init_data = 16'h0201;
        @(negedge clk);
        init_exec = 1'b0;
        init_data = 16'h0000;
        vectors++;
        if (i2c_exec !== 1'b1 || i2c_data !== 16'h0201) begin
            miscompares++;
            $display("[TB] FAIL pass_exec: got exec=%b data=%h, want 1/0201", i2c_exec, i2c_data);
        end
        @(negedge clk);
        vectors++;
        if (i2c_exec !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL pass_exec_pulse: got exec=%b, want 0", i2c_exec);
        end
        i2c_done = 1'b1;
        #1;
        vectors++;
        if (init_i2c_done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pass_done: got init_i2c_done=%b, want 1", init_i2c_done);
        end
        @(negedge clk);
        i2c_done = 1'b0;
        vol_up   = 1'b1;
        @(negedge clk);
        vol_up = 1'b0;
        @(negedge clk);
        vectors++;
        if (phone_vol !== 6'd30) begin
            miscompares++;
            $display("[TB] FAIL pass_key_ignored: got phone=%0d, want 30", phone_vol);
        end
        init_done = 1'b1;
        serve(60);
        vectors++;
        if (cap_n !== 0) begin
            miscompares++;
            $display("[TB] FAIL pass_key_forgotten: got %0d writes, want 0", cap_n);
        end
    endtask

    task automatic test_single_up();
        logic [15:0] exp_w [0:3];
        exp_w[0] = 16'h68A2;
        exp_w[1] = 16'h6BA2;
        exp_w[2] = 16'h6CBF;
        exp_w[3] = 16'h6FBF;
        add_key(0, 3'b100);
        serve(200);
        vectors++;
        if (cap_n !== 4) begin
            miscompares++;
            $display("[TB] FAIL up_count: got %0d writes, want 4", cap_n);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[i] !== exp_w[i]) begin
                miscompares++;
                $display("[TB] FAIL up_word%0d: got %h, want %h", i, cap[i], exp_w[i]);
            end
        end
        vectors++;
        if (phone_vol !== 6'd34 || spk_vol !== 6'd63 || busy !== 1'b0 || err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL up_state: got phone=%0d spk=%0d busy=%b err=%b, want 34/63/0/0",
                     phone_vol, spk_vol, busy, err);
        end
    endtask

    task automatic test_floor();
        logic [15:0] exp_w [0:3];
        do_reset();
        exp_w[0] = vol_word(7'd52, 1'b0, 6'd0);
        exp_w[1] = vol_word(7'd53, 1'b0, 6'd0);
        exp_w[2] = vol_word(7'd54, 1'b0, 6'd27);
        exp_w[3] = vol_word(7'd55, 1'b0, 6'd27);
        for (int k = 0; k < 9; k++) add_key(2 * k, 3'b010);
        serve(300);
        vectors++;
        if (cap_n !== 8) begin
            miscompares++;
            $display("[TB] FAIL floor_count: got %0d writes, want 8", cap_n);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[4 + i] !== exp_w[i]) begin
                miscompares++;
                $display("[TB] FAIL floor_word%0d: got %h, want %h", i, cap[4 + i], exp_w[i]);
            end
        end
        vectors++;
        if (phone_vol !== 6'd0 || spk_vol !== 6'd27) begin
            miscompares++;
            $display("[TB] FAIL floor_vol: got phone=%0d spk=%0d, want 0/27", phone_vol, spk_vol);
        end
        add_key(0, 3'b110);
        serve(80);
        vectors++;
        if (cap_n !== 0 || phone_vol !== 6'd0 || spk_vol !== 6'd27 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL updown_cancel: got writes=%0d phone=%0d spk=%0d busy=%b, want 0/0/27/0",
                     cap_n, phone_vol, spk_vol, busy);
        end
    endtask

    task automatic test_coalescing();
        logic [15:0] exp_w [0:3];
        do_reset();
        exp_w[0] = vol_word(7'd52, 1'b1, 6'd42);
        exp_w[1] = vol_word(7'd53, 1'b1, 6'd42);
        exp_w[2] = vol_word(7'd54, 1'b1, 6'd63);
        exp_w[3] = vol_word(7'd55, 1'b1, 6'd63);
        add_key(0, 3'b001);
        add_key(10, 3'b100);
        add_key(14, 3'b100);
        add_key(18, 3'b100);
        serve(300);
        vectors++;
        if (cap_n !== 8) begin
            miscompares++;
            $display("[TB] FAIL coal_count: got %0d writes, want 8", cap_n);
        end
        vectors++;
        if (cap[0] !== vol_word(7'd52, 1'b1, 6'd30)) begin
            miscompares++;
            $display("[TB] FAIL coal_first: got %h, want %h", cap[0], vol_word(7'd52, 1'b1, 6'd30));
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cap[4 + i] !== exp_w[i]) begin
                miscompares++;
                $display("[TB] FAIL coal_word%0d: got %h, want %h", i, cap[4 + i], exp_w[i]);
            end
        end
        vectors++;
        if (phone_vol !== 6'd42 || muted !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL coal_state: got phone=%0d muted=%b busy=%b, want 42/1/0",
                     phone_vol, muted, busy);
        end
    endtask

    task automatic test_mute();
        do_reset();
        add_key(0, 3'b001);
        serve(150);
        vectors++;
        if (cap_n !== 4 || cap[0] !== 16'h68DE || muted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mute_on: got writes=%0d r52=%h muted=%b, want 4/68de/1",
                     cap_n, cap[0], muted);
        end
        add_key(0, 3'b001);
        serve(150);
        vectors++;
        if (cap_n !== 4 || cap[0] !== 16'h689E || muted !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mute_off: got writes=%0d r52=%h muted=%b, want 4/689e/0",
                     cap_n, cap[0], muted);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        bit early;
        int extra;
        do_reset();
        @(negedge clk);
        vol_up = 1'b1;
        seen   = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            vol_up = 1'b0;
            if (i2c_exec) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL to_exec: got no exec within 10 cycles, want one");
        end
        early = 1'b0;
        for (int k = 0; k < int'(TO); k++) begin
            @(negedge clk);
            if (err) early = 1'b1;
        end
        vectors++;
        if (early) begin
            miscompares++;
            $display("[TB] FAIL to_early: got err=1 before %0d cycles, want 0", TO);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL to_err: got err=%b busy=%b, want 1/0", err, busy);
        end
        extra = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (i2c_exec) extra++;
        end
        vectors++;
        if (extra !== 0 || err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL to_after: got execs=%0d err=%b, want 0/1", extra, err);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit seen;
        int extra;
        @(negedge clk);
        vol_down = 1'b1;
        seen     = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            vol_down = 1'b0;
            if (i2c_exec) seen = 1'b1;
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (!seen || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rst_busy: got exec_seen=%b busy=%b, want 1/1", seen, busy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({i2c_exec, i2c_data, init_i2c_done, muted, busy, err} !== 20'd0 ||
            phone_vol !== 6'd30 || spk_vol !== 6'd63) begin
            miscompares++;
            $display("[TB] FAIL rst_mid: got exec=%b data=%h idone=%b phone=%0d spk=%0d muted=%b busy=%b err=%b, want reset values",
                     i2c_exec, i2c_data, init_i2c_done, phone_vol, spk_vol, muted, busy, err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (i2c_exec) extra++;
        end
        vectors++;
        if (extra !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_abandon: got execs=%0d busy=%b, want 0/0", extra, busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        sched_n     = 0;
        cap_n       = 0;
        rst_n       = 1'b0;
        init_exec   = 1'b0;
        init_data   = 16'h0000;
        init_done   = 1'b0;
        vol_up      = 1'b0;
        vol_down    = 1'b0;
        mute        = 1'b0;
        i2c_done    = 1'b0;
        repeat (3) @(negedge clk);

        test_reset();
        test_pass_through();
        test_single_up();
        test_floor();
        test_coalescing();
        test_mute();
        test_timeout();
        test_reset_mid_burst();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
